// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester front end for a single-port strobe-protocol ram.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed req0 priority on ties.
module ram_arbiter #(
    parameter int WORD_SIZE   = 27,
    parameter int WORD_AMOUNT = 37,
    localparam int ADDR_W     = $clog2(WORD_AMOUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_write,
    input  logic [ADDR_W-1:0]    req0_addr,
    input  logic [WORD_SIZE-1:0] req0_wdata,
    output logic                 req0_done,
    output logic                 req0_err,
    output logic [WORD_SIZE-1:0] req0_rdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_write,
    input  logic [ADDR_W-1:0]    req1_addr,
    input  logic [WORD_SIZE-1:0] req1_wdata,
    output logic                 req1_done,
    output logic                 req1_err,
    output logic [WORD_SIZE-1:0] req1_rdata,
    output logic [ADDR_W-1:0]    ram_address,
    output logic                 ram_select,
    output logic                 ram_operation,
    output logic [WORD_SIZE-1:0] ram_wdata,
    input  logic [WORD_SIZE-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RELEASE,
        ERR
    } state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(WORD_AMOUNT);

    state_t state;
    state_t next_state;

    logic                 grant;
    logic                 pick1;
    logic                 accept;
    logic                 bad;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_write;
    logic [WORD_SIZE-1:0] sel_wdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // req0 wins whenever it is requesting
    assign pick1 = req1_valid & ~req0_valid;
`else
    logic last_grant;

    // round-robin: a tie goes to the requester not served last
    assign pick1 = req1_valid & (~req0_valid | ~last_grant);

    // remember the most recent winner, erroring requests included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= pick1;
        end
    end
`endif

    assign accept    = (state == IDLE) & (req0_valid | req1_valid);
    assign sel_addr  = pick1 ? req1_addr  : req0_addr;
    assign sel_write = pick1 ? req1_write : req0_write;
    assign sel_wdata = pick1 ? req1_wdata : req0_wdata;
    assign bad       = {1'b0, sel_addr} >= LIMIT;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = bad ? ERR : SETUP;
                end
            end
            SETUP:   next_state = STROBE;
            STROBE:  next_state = RELEASE;
            RELEASE: next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: handshake, strobe and completion pulses
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ram_select = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        req0_err   = 1'b0;
        req1_err   = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = ~rst;
                req1_ready = ~rst;
            end
            STROBE: begin
                ram_select = 1'b1;
            end
            RELEASE: begin
                req0_done = ~grant;
                req1_done = grant;
            end
            ERR: begin
                req0_err = ~grant;
                req1_err = grant;
            end
            default: ;
        endcase
    end

    // latch the winner and its access onto the ram bus; bus holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant         <= 1'b0;
            ram_address   <= '0;
            ram_operation <= 1'b0;
            ram_wdata     <= '0;
        end else if (accept) begin
            grant <= pick1;
            if (!bad) begin
                ram_address   <= sel_addr;
                ram_operation <= sel_write;
                ram_wdata     <= sel_wdata;
            end
        end
    end

    // capture read data as the strobe cycle ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else if (state == STROBE && !ram_operation) begin
            if (grant) begin
                req1_rdata <= ram_rdata;
            end else begin
                req0_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural ram.
// Honours RAM_ARB_FIXED_PRIO_EN for the expected tie order.
module tb_ram_arbiter;

    localparam int WS = 27;
    localparam int WA = 37;
    localparam int AW = 6;
    localparam int BIG = 134217727;

    typedef struct {
        bit          w;
        logic [AW-1:0] a;
        logic [WS-1:0] d;
    } rq_t;

    typedef struct {
        int          p;
        bit          e;
        logic [WS-1:0] rd;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]    valid = '0;
    logic [1:0]    write = '0;
    logic [1:0]    ready;
    logic [1:0]    done;
    logic [1:0]    err;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [WS-1:0] wdata0 = '0;
    logic [WS-1:0] wdata1 = '0;
    logic [WS-1:0] rdata0;
    logic [WS-1:0] rdata1;

    logic [AW-1:0] ram_address;
    logic          ram_select;
    logic          ram_operation;
    logic [WS-1:0] ram_wdata;
    logic [WS-1:0] ram_rdata;
    logic [WS-1:0] mem [WA];

    rq_t rq0[$];
    rq_t rq1[$];
    ev_t sb[$];
    int  done_log[$];
    logic [WS-1:0] last_rd [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel_cnt = 0;
    int last_rdy = 0;
    ev_t mev;

    ram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (valid[0]),
        .req0_ready    (ready[0]),
        .req0_write    (write[0]),
        .req0_addr     (addr0),
        .req0_wdata    (wdata0),
        .req0_done     (done[0]),
        .req0_err      (err[0]),
        .req0_rdata    (rdata0),
        .req1_valid    (valid[1]),
        .req1_ready    (ready[1]),
        .req1_write    (write[1]),
        .req1_addr     (addr1),
        .req1_wdata    (wdata1),
        .req1_done     (done[1]),
        .req1_err      (err[1]),
        .req1_rdata    (rdata1),
        .ram_address   (ram_address),
        .ram_select    (ram_select),
        .ram_operation (ram_operation),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural single-port ram: async read, write on strobe
    assign ram_rdata = (int'(ram_address) < WA) ? mem[ram_address] : '0;

    always @(posedge clk) begin
        if (ram_select && ram_operation && int'(ram_address) < WA)
            mem[ram_address] <= ram_wdata;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void put(int p, bit w, int a, int d);
        rq_t r;
        r.w = w;
        r.a = AW'(a);
        r.d = WS'(d);
        if (p == 0) rq0.push_back(r);
        else rq1.push_back(r);
    endfunction

    function automatic void expect_ev(int p, bit e, logic [WS-1:0] rd);
        ev_t x;
        x.p = p;
        x.e = e;
        x.rd = rd;
        sb.push_back(x);
    endfunction

    function automatic void wr(int p, int a, int d);
        expect_ev(p, 1'b0, last_rd[p]);
        put(p, 1'b1, a, d);
    endfunction

    function automatic void rd(int p, int a, int d);
        expect_ev(p, 1'b0, WS'(d));
        last_rd[p] = WS'(d);
        put(p, 1'b0, a, 0);
    endfunction

    function automatic void bad(int p, int a);
        expect_ev(p, 1'b1, last_rd[p]);
        put(p, 1'b0, a, 0);
    endfunction

    task automatic run();
        int n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || sb.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL drain_timeout: pending rq0=%0d rq1=%0d sb=%0d expected 0",
                     rq0.size(), rq1.size(), sb.size());
            rq0.delete();
            rq1.delete();
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    // request drivers: hold each request until its own done/err
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                valid = '0;
            end else begin
                if ((done[0] || err[0]) && rq0.size() != 0) void'(rq0.pop_front());
                if ((done[1] || err[1]) && rq1.size() != 0) void'(rq1.pop_front());
                if (rq0.size() != 0) begin
                    valid[0] = 1'b1;
                    write[0] = rq0[0].w;
                    addr0    = rq0[0].a;
                    wdata0   = rq0[0].d;
                end else begin
                    valid[0] = 1'b0;
                end
                if (rq1.size() != 0) begin
                    valid[1] = 1'b1;
                    write[1] = rq1[0].w;
                    addr1    = rq1[0].a;
                    wdata1   = rq1[0].d;
                end else begin
                    valid[1] = 1'b0;
                end
            end
        end
    end

    // monitor: compare each completion against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            sel_cnt = 0;
        end else begin
            if (ram_select) sel_cnt++;
            if (ram_select || done != 2'b00 || err != 2'b00)
                chk("ready_busy", 32'(ready), 0);
            if (ready[0] && valid != 2'b00) last_rdy = cyc;
            for (int p = 0; p < 2; p++) begin
                if (done[p] || err[p]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: port %0d done=%0d err=%0d expected none",
                                 p, done[p], err[p]);
                    end else begin
                        mev = sb.pop_front();
                        chk("grant_port", p, mev.p);
                        chk("is_err", 32'(err[p]), 32'(mev.e));
                        chk("rdata", 32'(p == 1 ? rdata1 : rdata0), 32'(mev.rd));
                        chk("select_cycles", sel_cnt, mev.e ? 0 : 1);
                        chk("latency", cyc - last_rdy, mev.e ? 1 : 3);
                    end
                    if (done[p]) done_log.push_back(cyc);
                    sel_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < WA; i++) mem[i] = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_select", 32'(ram_select), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("idle_ready", 32'(ready), 3);
        chk("idle_addr", 32'(ram_address), 0);
        chk("idle_op", 32'(ram_operation), 0);

        // ties straight after reset
`ifdef RAM_ARB_FIXED_PRIO_EN
        expect_ev(0, 1'b0, '0);
        expect_ev(0, 1'b0, '0);
        expect_ev(0, 1'b0, '0);
        expect_ev(1, 1'b0, '0);
`else
        expect_ev(0, 1'b0, '0);
        expect_ev(1, 1'b0, '0);
        expect_ev(0, 1'b0, '0);
        expect_ev(0, 1'b0, '0);
`endif
        put(0, 1'b1, 1, 100);
        put(0, 1'b1, 2, 101);
        put(0, 1'b1, 3, 102);
        put(1, 1'b1, 4, 200);
        run();

        // write then read from the other requester
        wr(0, 0, 7);
        run();
        rd(1, 0, 7);
        run();

        // boundary addresses
        wr(0, 20, 11);
        wr(0, 36, BIG);
        run();
        rd(1, 20, 11);
        run();
        rd(0, 36, BIG);
        run();

        // out-of-range address, then a normal access
        bad(0, 37);
        rd(0, 20, 11);
        run();

        // reset in the middle of a write strobe
        put(0, 1'b1, 0, 55);
        begin
            int n = 0;
            while (!ram_select && n < 50) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("strobe_seen", 32'(ram_select), 1);
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_select", 32'(ram_select), 0);
        chk("rst_mid_ready", 32'(ready), 0);
        rq0.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_rdata0", 32'(rdata0), 0);
        chk("rst_rdata1", 32'(rdata1), 0);
        chk("rst_addr", 32'(ram_address), 0);
        rd(0, 0, 7);
        run();

        // back-to-back reads from one requester
        done_log.delete();
        rd(1, 20, 11);
        rd(1, 36, BIG);
        rd(1, 0, 7);
        run();
        chk("b2b_count", done_log.size(), 3);
        if (done_log.size() == 3) begin
            chk("b2b_gap1", done_log[1] - done_log[0], 4);
            chk("b2b_gap2", done_log[2] - done_log[1], 4);
        end

        // read back the tie-test writes
        rd(0, 1, 100);
        rd(0, 2, 101);
        rd(0, 3, 102);
        run();
        rd(1, 4, 200);
        run();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
